// File: rtl/cpu_reg_bank_pkg.sv
// Shared types and helpers for the CPU register bank: FSM state encoding,
// the read-back pattern for bad addresses, and the byte-address decoder.
package cpu_reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Read-back pattern for illegal addresses, replicated/truncated to the data width by the user.
  localparam logic [31:0] ERR_READ_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        valid;
    logic [31:0] index;
  } decode_t;

  // Byte address -> register index. Valid only when the address is at or above base,
  // aligned to the register size (2**shift bytes) and inside the bank.
  function automatic decode_t addr_to_index(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input int unsigned shift,
                                            input int unsigned num_regs);
    decode_t     d;
    logic [63:0] offset;
    logic [63:0] mask;
    logic [63:0] idx_full;
    offset   = addr - base;
    mask     = (64'd1 << shift) - 64'd1;
    idx_full = offset >> shift;
    d.index  = idx_full[31:0];
    d.valid  = (addr >= base) && ((offset & mask) == 64'd0) && (idx_full < 64'(num_regs));
    return d;
  endfunction

endpackage

// File: rtl/cpu_reg_bank_ctrl.sv
// Access sequencer for the CPU register bank: accepts one request at a time,
// waits a fixed number of cycles and emits a single completion pulse.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request (ready=1 from the first edge after reset)
//   WAIT  | request accepted, down-counter running towards terminal count
//   DONE  | completion pulse cycle; returns to IDLE on the next edge
module cpu_reg_bank_ctrl
  import cpu_reg_bank_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic accept,
  output logic enter_done,
  output logic ready,
  output logic complete
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

  state_t     state;
  logic [3:0] cnt;

  // Acceptance and the DONE-entry strobe used by the datapath to update read data.
  always_comb begin
    accept     = req & ready;
    enter_done = 1'b0;
    if ((state == IDLE) && accept && NO_WAIT)
      enter_done = 1'b1;
    if ((state == WAIT) && (cnt == 4'd0))
      enter_done = 1'b1;
  end

  // Sequencer with registered ready/complete outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      complete <= 1'b0;
    end else begin
      ready    <= 1'b0;
      complete <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (NO_WAIT) begin
              state    <= DONE;
              complete <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end else begin
            ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            complete <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_reg_bank.sv
// CPU register bank target on the destination-clock CPU bus.
// Holds NUM_REGS software registers exported flat on reg_q and answers each
// accepted access with a completion pulse after WAIT_CYCLES extra cycles.
// Optional feature macro: CPU_REG_BANK_ERR_EN adds cpu_m_access_error and
// returns the DEADBEEF pattern for reads of illegal addresses.
module cpu_reg_bank
  import cpu_reg_bank_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH  = 32,
  parameter int unsigned              DATA_WIDTH  = 32,
  parameter int unsigned              NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = '0,
  parameter int unsigned              WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0]    RESET_VAL   = '0
) (
  input  logic                           cpu_m_clk,
  input  logic                           cpu_m_reset,
  input  logic                           cpu_m_write,
  input  logic                           cpu_m_read,
  input  logic [ADDR_WIDTH-1:0]          cpu_m_address,
  input  logic [DATA_WIDTH-1:0]          cpu_m_write_data,
  output logic [DATA_WIDTH-1:0]          cpu_m_read_data,
  output logic                           cpu_m_access_ready,
  output logic                           cpu_m_access_complete,
`ifdef CPU_REG_BANK_ERR_EN
  output logic                           cpu_m_access_error,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef CPU_REG_BANK_ERR_EN
  function automatic logic [DATA_WIDTH-1:0] err_word();
    logic [DATA_WIDTH-1:0] w;
    for (int i = 0; i < int'(DATA_WIDTH); i++)
      w[i] = ERR_READ_DATA[i % 32];
    return w;
  endfunction
  localparam logic [DATA_WIDTH-1:0] BAD_WORD = err_word();
`else
  localparam logic [DATA_WIDTH-1:0] BAD_WORD = '0;
`endif

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  decode_t               dec;
  logic [IDX_W-1:0]      idx;
  logic                  unused_idx_bits;
  logic                  accept;
  logic                  enter_done;
  logic [DATA_WIDTH-1:0] live_rdata;
  logic                  live_rd_op;
  logic                  rd_op_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  done_rd_op;
  logic [DATA_WIDTH-1:0] done_rdata;

  assign dec             = addr_to_index(64'(cpu_m_address), 64'(BASE_ADDR), SHIFT, NUM_REGS);
  assign idx             = dec.index[IDX_W-1:0];
  assign unused_idx_bits = ^dec.index;

  cpu_reg_bank_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk        (cpu_m_clk),
    .rst_n      (cpu_m_reset),
    .req        (cpu_m_write | cpu_m_read),
    .accept     (accept),
    .enter_done (enter_done),
    .ready      (cpu_m_access_ready),
    .complete   (cpu_m_access_complete)
  );

  // Read mux for the addressed register; illegal addresses read back BAD_WORD.
  always_comb begin
    live_rdata = BAD_WORD;
    if (dec.valid)
      live_rdata = regs[idx];
  end

  // A simultaneous write wins, so only a pure read returns data.
  assign live_rd_op = cpu_m_read & ~cpu_m_write;

  // With zero wait the access completes on its acceptance edge, so use live values then.
  assign done_rd_op = accept ? live_rd_op : rd_op_q;
  assign done_rdata = accept ? live_rdata : rd_data_q;

  // Register array: written on the acceptance edge for legal addresses only.
  always_ff @(posedge cpu_m_clk or negedge cpu_m_reset) begin
    if (!cpu_m_reset) begin
      for (int k = 0; k < int'(NUM_REGS); k++)
        regs[k] <= RESET_VAL;
    end else if (accept && cpu_m_write && dec.valid) begin
      regs[idx] <= cpu_m_write_data;
    end
  end

  // Capture the read operation and its data at acceptance.
  always_ff @(posedge cpu_m_clk or negedge cpu_m_reset) begin
    if (!cpu_m_reset) begin
      rd_op_q   <= 1'b0;
      rd_data_q <= '0;
    end else if (accept) begin
      rd_op_q   <= live_rd_op;
      rd_data_q <= live_rdata;
    end
  end

  // Read data changes only when a read completes; writes leave it untouched.
  always_ff @(posedge cpu_m_clk or negedge cpu_m_reset) begin
    if (!cpu_m_reset)
      cpu_m_read_data <= '0;
    else if (enter_done && done_rd_op)
      cpu_m_read_data <= done_rdata;
  end

`ifdef CPU_REG_BANK_ERR_EN
  logic live_err;
  logic err_q;

  assign live_err = ~dec.valid | (cpu_m_read & cpu_m_write);

  // Error flag captured at acceptance and presented only alongside the completion pulse.
  always_ff @(posedge cpu_m_clk or negedge cpu_m_reset) begin
    if (!cpu_m_reset) begin
      err_q              <= 1'b0;
      cpu_m_access_error <= 1'b0;
    end else begin
      if (accept)
        err_q <= live_err;
      cpu_m_access_error <= enter_done ? (accept ? live_err : err_q) : 1'b0;
    end
  end
`endif

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regq
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
